// File: rtl/output_unit.sv
// output_unit: credit-tracked transmit endpoint with link register and sticky protocol checks
module output_unit #(
    parameter int BIT_WIDTH    = 32,
    parameter int CREDIT_DEPTH = 8,
    parameter int CNT_WIDTH    = $clog2(CREDIT_DEPTH + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_credit_decre,
    output logic                 o_credit_avail,
    output logic [CNT_WIDTH-1:0] o_credit_count,
    input  logic                 i_st_valid,
    input  logic [BIT_WIDTH-1:0] i_st_data,
    output logic                 o_out_data_valid,
    output logic [BIT_WIDTH-1:0] o_out_data,
    input  logic                 i_in_credit,
    output logic                 o_credit_error,
    output logic                 o_protocol_error
);
    localparam logic [CNT_WIDTH-1:0] LP_FULL = CNT_WIDTH'(CREDIT_DEPTH);

    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_pending;
    logic                 r_out_valid;
    logic [BIT_WIDTH-1:0] r_out_data;
    logic                 r_credit_error;
    logic                 r_protocol_error;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_dec;
    logic                 w_inc;
    logic                 w_cerr;
    logic                 w_perr;
    logic [CNT_WIDTH-1:0] w_cnt_next;

    // A grant at zero credits is dropped; a return at full credits is dropped unless a grant frees room.
    always_comb begin
        w_empty    = (r_cnt == '0);
        w_full     = (r_cnt == LP_FULL);
        w_dec      = i_credit_decre & ~w_empty;
        w_inc      = i_in_credit & ~(w_full & ~i_credit_decre);
        w_cnt_next = r_cnt - CNT_WIDTH'(w_dec) + CNT_WIDTH'(w_inc);
        w_cerr     = (i_credit_decre & w_empty) | (i_in_credit & w_full & ~i_credit_decre);
        w_perr     = i_st_valid ^ r_pending;
    end

    // Credit counter, grant-to-flit tracker, link register and sticky error flags.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_cnt            <= LP_FULL;
            r_pending        <= 1'b0;
            r_out_valid      <= 1'b0;
            r_out_data       <= '0;
            r_credit_error   <= 1'b0;
            r_protocol_error <= 1'b0;
        end else begin
            r_cnt            <= w_cnt_next;
            r_pending        <= w_dec;
            r_out_valid      <= i_st_valid;
            r_out_data       <= i_st_valid ? i_st_data : r_out_data;
            r_credit_error   <= r_credit_error | w_cerr;
            r_protocol_error <= r_protocol_error | w_perr;
        end
    end

    assign o_credit_count   = r_cnt;
    assign o_credit_avail   = (r_cnt != '0);
    assign o_out_data_valid = r_out_valid;
    assign o_out_data       = r_out_data;
    assign o_credit_error   = r_credit_error;
    assign o_protocol_error = r_protocol_error;
endmodule

// File: tb/tb_output_unit.sv
// tb_output_unit: directed and randomized checks of output_unit against a credit/flit model
module tb_output_unit;
    localparam int BW    = 32;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          decre = 1'b0;
    logic          in_credit = 1'b0;
    logic          st_valid = 1'b0;
    logic [BW-1:0] st_data = '0;
    logic          avail;
    logic [CW-1:0] count;
    logic          out_valid;
    logic [BW-1:0] out_data;
    logic          cerr;
    logic          perr;

    int passed = 0;
    int total = 0;
    bit chk_on = 1'b0;

    output_unit #(.BIT_WIDTH(BW), .CREDIT_DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst(rst), .i_credit_decre(decre), .o_credit_avail(avail),
        .o_credit_count(count), .i_st_valid(st_valid), .i_st_data(st_data),
        .o_out_data_valid(out_valid), .o_out_data(out_data), .i_in_credit(in_credit),
        .o_credit_error(cerr), .o_protocol_error(perr)
    );

    always #5 clk = ~clk;

    // Reference model: credits free slots, a grant owes exactly one flit next cycle.
    int          m_cnt = DEPTH;
    bit          m_pend = 0;
    bit          m_v = 0;
    logic [BW-1:0] m_d = '0;
    bit          m_ce = 0;
    bit          m_pe = 0;
    int          n_cnt;
    bit          n_ce;
    bit          granted;

    always_comb begin
        granted = decre && (m_cnt > 0);
        n_cnt = m_cnt;
        if (granted) n_cnt = n_cnt - 1;
        if (in_credit && n_cnt < DEPTH) n_cnt = n_cnt + 1;
        n_ce = m_ce || (decre && m_cnt == 0) || (in_credit && m_cnt == DEPTH && !decre);
    end

    always @(posedge clk) begin
        if (!rst) begin
            m_cnt <= DEPTH; m_pend <= 0; m_v <= 0; m_d <= '0; m_ce <= 0; m_pe <= 0;
        end else begin
            m_cnt  <= n_cnt;
            m_pend <= granted;
            m_v    <= st_valid;
            m_d    <= st_valid ? st_data : m_d;
            m_ce   <= n_ce;
            m_pe   <= m_pe || (st_valid != m_pend);
        end
    end

    function automatic void chk(string name, logic [BW-1:0] act, logic [BW-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("m_count", BW'(count), BW'(m_cnt));
            chk("m_avail", BW'(avail), BW'(m_cnt != 0));
            chk("m_valid", BW'(out_valid), BW'(m_v));
            chk("m_data", out_data, m_d);
            chk("m_cerr", BW'(cerr), BW'(m_ce));
            chk("m_perr", BW'(perr), BW'(m_pe));
        end
    end

    task automatic cyc(input bit d, input bit c, input bit sv, input logic [BW-1:0] sd);
        decre = d; in_credit = c; st_valid = sv; st_data = sd;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 0;
        cyc(0, 0, 0, 0);
        rst = 1;
    endtask

    initial begin
        rst = 0;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        rst = 1;
        chk_on = 1;
        chk("rst_count", BW'(count), 8);
        chk("rst_avail", BW'(avail), 1);
        chk("rst_valid", BW'(out_valid), 0);
        chk("rst_data", out_data, 0);
        chk("rst_cerr", BW'(cerr), 0);
        chk("rst_perr", BW'(perr), 0);
        for (int i = 0; i <= 8; i++) begin
            cyc(i < 8, 0, i > 0, BW'(i - 1));
            if (i < 8) chk("drain_count", BW'(count), BW'(7 - i));
            if (i > 0) chk("drain_data", out_data, BW'(i - 1));
        end
        chk("drain_avail", BW'(avail), 0);
        chk("drain_perr", BW'(perr), 0);
        cyc(1, 0, 0, 0);
        chk("under_count", BW'(count), 0);
        chk("under_cerr", BW'(cerr), 1);
        do_reset();
        chk("under_rst_cerr", BW'(cerr), 0);
        cyc(0, 1, 0, 0);
        chk("over_count", BW'(count), 8);
        chk("over_cerr", BW'(cerr), 1);
        do_reset();
        cyc(1, 1, 0, 0);
        chk("both8_count", BW'(count), 8);
        chk("both8_cerr", BW'(cerr), 0);
        for (int k = 0; k < 5; k++) cyc(1, 0, 1, BW'(16 + k));
        chk("pre3_count", BW'(count), 3);
        cyc(1, 1, 1, 32'h15);
        chk("both3_count", BW'(count), 3);
        cyc(0, 0, 1, 32'h16);
        chk("seq_perr", BW'(perr), 0);
        cyc(0, 0, 1, 32'hAB);
        chk("proto_data", out_data, 32'hAB);
        chk("proto_perr", BW'(perr), 1);
        do_reset();
        chk("proto_rst_perr", BW'(perr), 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("noflit_perr", BW'(perr), 1);
        do_reset();
        cyc(1, 0, 0, 0);
        for (int k = 0; k < 5; k++) cyc(1, 0, 1, BW'(k));
        chk("mid_count", BW'(count), 2);
        rst = 0;
        cyc(0, 0, 1, 32'h55);
        rst = 1;
        chk("mid_count_rst", BW'(count), 8);
        chk("mid_valid", BW'(out_valid), 0);
        chk("mid_perr", BW'(perr), 0);
        chk("mid_data", out_data, 0);
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 47) != 0);
            cyc($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
                ($urandom_range(0, 24) == 0) ? !m_pend : m_pend, $urandom);
        end
        rst = 1;
        chk_on = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/output_unit.md
# output_unit

Transmit-side endpoint of the credit-based router link. It sits after the crossbar on one output direction and tracks the downstream input FIFO's free slots in a credit counter. It drives that counter's availability bit back to the switch arbiter, registers switch-traversal flits onto the outgoing link, and flags credit and ST-ordering protocol violations.

## Interface
Parameters:
- `BIT_WIDTH`, default 32: flit width; equals the router link width.
- `CREDIT_DEPTH`, default 8: downstream buffer slots; this is the credit reset value.
- `CNT_WIDTH`, default `$clog2(CREDIT_DEPTH+1)` (4): credit counter width.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous reset, active-low (asserted when 0, sampled on the rising edge of `clk`).
- `credit_decre`  in  1  SA granted a flit to this output this cycle; consumes one credit.
- `credit_avail`  out  1  downstream has ≥1 free slot; feeds the arbiter's credit-available bit.
- `credit_count`  out  CNT_WIDTH  current credit value.
- `st_valid`  in  1  crossbar presents a flit this cycle.
- `st_data`  in  BIT_WIDTH  flit from the crossbar.
- `out_data_valid`  out  1  link flit valid toward the downstream router.
- `out_data`  out  BIT_WIDTH  link flit.
- `in_credit`  in  1  credit return pulse from downstream; one slot freed.
- `credit_error`  out  1  sticky; credit underflow or overflow occurred.
- `protocol_error`  out  1  sticky; `st_valid` was not preceded by `credit_decre`.

## Operation
- Credit counter `cnt`:
  - `cnt_next = cnt - dec + inc`, where `dec = credit_decre & (cnt != 0)` and `inc = in_credit & !(cnt == CREDIT_DEPTH & !credit_decre)`.
  - Simultaneous `credit_decre` and `in_credit` with `cnt > 0` leaves `cnt` unchanged.
  - Underflow: `credit_decre` while `cnt == 0`. The decrement is dropped and `credit_error` is set. A coincident `in_credit` is still applied (0→1).
  - Overflow: `in_credit` while `cnt == CREDIT_DEPTH` and no `credit_decre`. The increment is dropped and `credit_error` is set.
  - With both `credit_decre` and `in_credit` at `cnt == CREDIT_DEPTH`, the count is unchanged and no error is raised.
- `credit_avail = (cnt != 0)`. It is decoded from the register only; there is no bypass from `in_credit`.
- ST ordering: a 1-bit `pending` register is loaded with `dec` each cycle. `st_valid` is required exactly one cycle after an accepted `credit_decre`.
  - `st_valid & !pending` sets `protocol_error`; the flit is still forwarded.
  - `pending & !st_valid` also sets `protocol_error`, because a credit was consumed without a flit.
- Link register:
  - `out_data_valid <= st_valid`.
  - `out_data <= st_data` when `st_valid`; otherwise `out_data` holds its last value.
- The error flags are sticky until `rst`.
- Reset, including mid-operation:
  - `cnt = CREDIT_DEPTH`, `credit_avail = 1`, `pending = 0`.
  - `out_data_valid = 0`, `out_data = 0`.
  - `credit_error = 0`, `protocol_error = 0`.
  - In-flight flits and credits are discarded; downstream is reset together with this block.

## Timing
- Cycle t: `credit_decre` is sampled and `cnt` updates at the edge ending t, so `credit_avail` reflects it in t+1.
- Cycle t+1: `st_valid`/`st_data` are sampled; `out_data_valid`/`out_data` are asserted in t+2. ST-to-link latency is 1 cycle; SA-to-link is 2 cycles.
- An `in_credit` in cycle t raises `cnt` in t+1, so `credit_avail` can go 0→1 at t+1 at the earliest.
- Back-to-back grants: one `credit_decre` per cycle is sustainable while `cnt > 0`. At `cnt == 1`, a grant in t makes `credit_avail = 0` in t+1.
- The error flags assert in the cycle after the offending event.
- All outputs are registered or decoded from registers; there are no combinational input→output paths.

## Test plan
- Reset: hold `rst = 0` for 2 cycles, release. Expect `credit_count = 8`, `credit_avail = 1`, `out_data_valid = 0`, `out_data = 0`, both error flags 0.
- Drain:
  - Stimulus: 8 consecutive `credit_decre`, each followed next cycle by `st_valid` with data 0x00..0x07.
  - `credit_count` steps 8→0 and `credit_avail = 0` after the 8th grant.
  - `out_data` shows 0x00..0x07 two cycles after each grant.
  - `protocol_error = 0`.
- Simultaneous events:
  - At `cnt = 3`, assert `credit_decre` and `in_credit` together: `cnt` stays 3.
  - At `cnt = 8`, assert both: `cnt` stays 8, `credit_error = 0`.
- Underflow/overflow:
  - At `cnt = 0`, `credit_decre` alone: `cnt` stays 0 and `credit_error = 1`. Reset, then check the flag is 0.
  - At `cnt = 8`, `in_credit` alone: `cnt` stays 8 and `credit_error = 1`.
- Protocol:
  - `st_valid` with data 0xAB and no prior grant: `out_data = 0xAB` next cycle and `protocol_error = 1`.
  - After reset, a grant with no following `st_valid`: `protocol_error = 1`.
- Reset mid-operation:
  - At `cnt = 2` with `pending = 1`, pulse `rst = 0` for one cycle.
  - Expect `cnt = 8`, `out_data_valid = 0`, `protocol_error = 0`, and the late `st_valid` dropped by reset.
